// File: rtl/pc_seq_pkg.sv
// ---------------------------------------------------------------------------
// pc_seq_pkg
//   Shared types and constants for the fetch-side PC sequencer.
//   state_t : sequencer FSM states
//   PC_W    : program counter width
//   INSTR_W : instruction width
//   PC_INC  : sequential fetch increment
// ---------------------------------------------------------------------------
package pc_seq_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_IDLE  = 2'd1,
    S_REQ   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/pc_redirect_sel.sv
// ---------------------------------------------------------------------------
// pc_redirect_sel
//   Combinational redirect selection: exception > jump > branch, followed by
//   alignment handling of the selected target.
//   Build option PC_MISALIGN_TRAP_EN:
//     defined     - a misaligned target is replaced by TRAP_VEC and
//                   redir_misalign is raised
//     not defined - target[1:0] is forced to 2'b00, redir_misalign stays 0
// Ports:
//   exc_valid      in   exception redirect (target TRAP_VEC)
//   jmp_valid      in   jump redirect
//   jmp_target     in   jump target
//   br_taken       in   taken-branch redirect
//   br_target      in   branch target
//   redir_valid    out  any redirect requested this cycle
//   redir_target   out  selected, aligned redirect target
//   redir_misalign out  selected target was misaligned and trapped
// ---------------------------------------------------------------------------
module pc_redirect_sel
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
  input  logic            exc_valid,
  input  logic            jmp_valid,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic            redir_valid,
  output logic [PC_W-1:0] redir_target,
  output logic            redir_misalign
);

  logic [PC_W-1:0] raw_target;

  always_comb begin
    raw_target  = '0;
    redir_valid = exc_valid | jmp_valid | br_taken;
    if (exc_valid) begin
      raw_target = TRAP_VEC;
    end else if (jmp_valid) begin
      raw_target = jmp_target;
    end else if (br_taken) begin
      raw_target = br_target;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  always_comb begin
    redir_target   = raw_target;
    redir_misalign = 1'b0;
    if (raw_target[1:0] != 2'b00) begin
      redir_target   = TRAP_VEC;
      redir_misalign = redir_valid;
    end
  end
`else
  // Mask the low bits rather than slicing so every bit of raw_target is used.
  assign redir_target   = raw_target & ~32'd3;
  assign redir_misalign = 1'b0;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Fetch-side controller owning the 32-bit PC. Chooses the next PC
//   (sequential +4, branch, jump, exception), runs the req/ack handshake to
//   instruction memory and hands fetched instructions to decode.
//   Build option PC_MISALIGN_TRAP_EN: misaligned redirect targets trap to
//   TRAP_VEC and pulse misalign_trap (otherwise targets are word-aligned and
//   misalign_trap is always 0).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   stall           decode cannot accept a new instruction
//   exc_valid       exception redirect to TRAP_VEC
//   jmp_valid/jmp_target   jump redirect
//   br_taken/br_target     taken-branch redirect
//   imem_req/imem_addr     fetch request and address
//   imem_ack/imem_rdata    request completion and fetched instruction
//   fetch_valid/fetch_instr/fetch_pc  registered instruction to decode
//   flush           1-cycle pulse after a redirect is accepted
//   misalign_trap   1-cycle pulse with flush when a misaligned target trapped
// ---------------------------------------------------------------------------
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0080
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               exc_valid,
  input  logic               jmp_valid,
  input  logic [PC_W-1:0]    jmp_target,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               fetch_valid,
  output logic [INSTR_W-1:0] fetch_instr,
  output logic [PC_W-1:0]    fetch_pc,
  output logic               flush,
  output logic               misalign_trap
);

  state_t             state_reg,         state_next;
  logic [PC_W-1:0]    pc_reg,            pc_next;
  logic [PC_W-1:0]    pend_pc_reg,       pend_pc_next;
  logic               fetch_valid_reg,   fetch_valid_next;
  logic [INSTR_W-1:0] fetch_instr_reg,   fetch_instr_next;
  logic [PC_W-1:0]    fetch_pc_reg,      fetch_pc_next;
  logic               flush_reg,         flush_next;
  logic               misalign_trap_reg, misalign_trap_next;

  logic            redir_valid;
  logic [PC_W-1:0] redir_target;
  logic            redir_misalign;

  pc_redirect_sel #(
    .TRAP_VEC (TRAP_VEC)
  ) u_redirect_sel (
    .exc_valid      (exc_valid),
    .jmp_valid      (jmp_valid),
    .jmp_target     (jmp_target),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .redir_valid    (redir_valid),
    .redir_target   (redir_target),
    .redir_misalign (redir_misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= S_BOOT;
      pc_reg            <= RESET_VEC;
      pend_pc_reg       <= '0;
      fetch_valid_reg   <= 1'b0;
      fetch_instr_reg   <= '0;
      fetch_pc_reg      <= '0;
      flush_reg         <= 1'b0;
      misalign_trap_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      pc_reg            <= pc_next;
      pend_pc_reg       <= pend_pc_next;
      fetch_valid_reg   <= fetch_valid_next;
      fetch_instr_reg   <= fetch_instr_next;
      fetch_pc_reg      <= fetch_pc_next;
      flush_reg         <= flush_next;
      misalign_trap_reg <= misalign_trap_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    pc_next            = pc_reg;
    pend_pc_next       = pend_pc_reg;
    fetch_valid_next   = 1'b0;
    fetch_instr_next   = fetch_instr_reg;
    fetch_pc_next      = fetch_pc_reg;
    flush_next         = 1'b0;
    misalign_trap_next = 1'b0;

    case (state_reg)
      // One dead cycle after reset; any stray ack from a dropped request
      // lands here and is ignored.
      S_BOOT: begin
        state_next = stall ? S_IDLE : S_REQ;
      end

      S_IDLE: begin
        if (redir_valid) begin
          pc_next            = redir_target;
          flush_next         = 1'b1;
          misalign_trap_next = redir_misalign;
        end
        state_next = stall ? S_IDLE : S_REQ;
      end

      S_REQ: begin
        if (imem_ack) begin
          if (redir_valid) begin
            // Returned word belongs to the wrong path: drop it.
            pc_next            = redir_target;
            flush_next         = 1'b1;
            misalign_trap_next = redir_misalign;
          end else begin
            fetch_valid_next = 1'b1;
            fetch_instr_next = imem_rdata;
            fetch_pc_next    = pc_reg;
            pc_next          = pc_reg + PC_INC;
          end
          state_next = stall ? S_IDLE : S_REQ;
        end else if (redir_valid) begin
          // Request is still in flight and must stay stable; park the
          // target until the ack retires the old request.
          pend_pc_next       = redir_target;
          flush_next         = 1'b1;
          misalign_trap_next = redir_misalign;
          state_next         = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (redir_valid) begin
          flush_next         = 1'b1;
          misalign_trap_next = redir_misalign;
        end
        if (imem_ack) begin
          // Latest redirect wins, including one arriving with the ack.
          pc_next    = redir_valid ? redir_target : pend_pc_reg;
          state_next = stall ? S_IDLE : S_REQ;
        end else if (redir_valid) begin
          pend_pc_next = redir_target;
        end
      end

      default: begin
        state_next = S_BOOT;
      end
    endcase
  end

  // Address is the PC register itself, so it cannot move while a request
  // is outstanding (pc only changes on ack or outside S_REQ/S_DRAIN).
  assign imem_req      = (state_reg == S_REQ) || (state_reg == S_DRAIN);
  assign imem_addr     = pc_reg;
  assign fetch_valid   = fetch_valid_reg;
  assign fetch_instr   = fetch_instr_reg;
  assign fetch_pc      = fetch_pc_reg;
  assign flush         = flush_reg;
  assign misalign_trap = misalign_trap_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        exc_valid;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        flush;
  logic        misalign_trap;

  int checks   = 0;
  int failures = 0;

  pc_sequencer #(
    .RESET_VEC (32'h0000_0000),
    .TRAP_VEC  (32'h0000_0080)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .exc_valid     (exc_valid),
    .jmp_valid     (jmp_valid),
    .jmp_target    (jmp_target),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .fetch_valid   (fetch_valid),
    .fetch_instr   (fetch_instr),
    .fetch_pc      (fetch_pc),
    .flush         (flush),
    .misalign_trap (misalign_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check request / flush / fetch_valid together.
  task automatic chk_ctl(input string tag, input logic req, input logic [31:0] addr,
                         input logic fv, input logic fl);
    chk({tag, ".req"},   {31'd0, imem_req},    {31'd0, req});
    chk({tag, ".addr"},  imem_addr,            addr);
    chk({tag, ".fv"},    {31'd0, fetch_valid}, {31'd0, fv});
    chk({tag, ".flush"}, {31'd0, flush},       {31'd0, fl});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    exc_valid = 1'b0; jmp_valid = 1'b0; jmp_target = '0;
    br_taken = 1'b0; br_target = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    tick(); tick();

    // Reset state
    chk_ctl("reset", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("reset.fetch_pc", fetch_pc, 32'h0);
    chk("reset.fetch_instr", fetch_instr, 32'h0);
    chk("reset.mis", {31'd0, misalign_trap}, 32'h0);

    // Sequential fetch, ack every cycle (ack in BOOT ignored)
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_0000;
    tick();
    chk_ctl("boot", 1'b1, 32'h0, 1'b0, 1'b0);
    imem_rdata = 32'hA000_0000;
    tick();
    chk_ctl("seq0", 1'b1, 32'h4, 1'b1, 1'b0);
    chk("seq0.pc", fetch_pc, 32'h0);
    chk("seq0.instr", fetch_instr, 32'hA000_0000);
    imem_rdata = 32'hA000_0004;
    tick();
    chk_ctl("seq1", 1'b1, 32'h8, 1'b1, 1'b0);
    chk("seq1.pc", fetch_pc, 32'h4);
    chk("seq1.instr", fetch_instr, 32'hA000_0004);

    // Branch with ack: data dropped, redirect to 0x100
    br_taken = 1'b1; br_target = 32'h100; imem_rdata = 32'h0000_0BAD;
    tick();
    chk_ctl("br_ack", 1'b1, 32'h100, 1'b0, 1'b1);
    chk("br_ack.pc", fetch_pc, 32'h4);
    br_taken = 1'b0; imem_ack = 1'b0;
    tick();
    chk_ctl("br_wait", 1'b1, 32'h100, 1'b0, 1'b0);

    // Jump without ack: address held through drain
    jmp_valid = 1'b1; jmp_target = 32'h200;
    tick();
    chk_ctl("jmp_red", 1'b1, 32'h100, 1'b0, 1'b1);
    jmp_valid = 1'b0;
    tick();
    chk_ctl("drain1", 1'b1, 32'h100, 1'b0, 1'b0);
    tick();
    chk_ctl("drain2", 1'b1, 32'h100, 1'b0, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'h0000_DEAD;
    tick();
    chk_ctl("drain_ack", 1'b1, 32'h200, 1'b0, 1'b0);
    imem_rdata = 32'h1111_0200;
    tick();
    chk_ctl("at200", 1'b1, 32'h204, 1'b1, 1'b0);
    chk("at200.pc", fetch_pc, 32'h200);
    chk("at200.instr", fetch_instr, 32'h1111_0200);

    // All three redirects at once: exception wins
    imem_ack = 1'b0; exc_valid = 1'b1; jmp_valid = 1'b1; jmp_target = 32'h300;
    br_taken = 1'b1; br_target = 32'h400;
    tick();
    chk_ctl("exc_red", 1'b1, 32'h204, 1'b0, 1'b1);
    exc_valid = 1'b0; jmp_valid = 1'b0; br_taken = 1'b0; imem_ack = 1'b1;
    tick();
    chk_ctl("exc_done", 1'b1, 32'h80, 1'b0, 1'b0);

    // Jump to top of address space with ack, then wrap with stall
    jmp_valid = 1'b1; jmp_target = 32'hFFFF_FFFC;
    tick();
    chk_ctl("to_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    jmp_valid = 1'b0; stall = 1'b1; imem_rdata = 32'h5A5A_5A5A;
    tick();
    chk_ctl("wrap", 1'b0, 32'h0, 1'b1, 1'b0);
    chk("wrap.pc", fetch_pc, 32'hFFFF_FFFC);
    chk("wrap.instr", fetch_instr, 32'h5A5A_5A5A);
    imem_ack = 1'b0;
    tick();
    chk_ctl("idle_stall", 1'b0, 32'h0, 1'b0, 1'b0);
    stall = 1'b0;
    tick();
    chk_ctl("idle_go", 1'b1, 32'h0, 1'b0, 1'b0);

    // Stall never withdraws an outstanding request
    stall = 1'b1;
    tick();
    chk_ctl("stall_hold", 1'b1, 32'h0, 1'b0, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0077;
    tick();
    chk_ctl("stall_ack", 1'b0, 32'h4, 1'b1, 1'b0);
    chk("stall_ack.instr", fetch_instr, 32'h0000_0077);
    stall = 1'b0; imem_ack = 1'b0;
    tick();
    chk_ctl("resume", 1'b1, 32'h4, 1'b0, 1'b0);

    // Misaligned branch target
    br_taken = 1'b1; br_target = 32'h102;
    tick();
    chk_ctl("mis_red", 1'b1, 32'h4, 1'b0, 1'b1);
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_red.trap", {31'd0, misalign_trap}, 32'h1);
`else
    chk("mis_red.trap", {31'd0, misalign_trap}, 32'h0);
`endif
    br_taken = 1'b0; imem_ack = 1'b1;
    tick();
`ifdef PC_MISALIGN_TRAP_EN
    chk_ctl("mis_done", 1'b1, 32'h80, 1'b0, 1'b0);
`else
    chk_ctl("mis_done", 1'b1, 32'h100, 1'b0, 1'b0);
`endif
    chk("mis_done.trap", {31'd0, misalign_trap}, 32'h0);

    // Reset mid-request; late ack in BOOT ignored
    imem_ack = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk_ctl("rst_mid", 1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    chk_ctl("rst_boot", 1'b1, 32'h0, 1'b0, 1'b0);
    chk("rst_boot.instr", fetch_instr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
